// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad blocks.
// Column patterns are active-low: a pressed key pulls exactly one bit to 0.
package keypad_pkg;
   typedef enum logic [1:0] {SCAN, CONFIRM, REPORT, RELEASE} state_t;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int KEY_W = 4;
   localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

   function automatic logic one_low(input logic [COLS-1:0] c);
      return $countones(~c) == 1;
   endfunction

   function automatic logic [1:0] low_pos(input logic [COLS-1:0] c);
      logic [1:0] p;
      p = '0;
      for (int i = 0; i < COLS; i++)
         if (!c[i]) p = 2'(i);
      return p;
   endfunction
endpackage

// File: rtl/keypad_scan_driver_col_sync.sv
// Generic 2-FF synchronizer, resets to all-ones (idle for pulled-up lines).
// Latency 2 clk; no flow control.
module col_sync #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/keypad_scan_driver.sv
// Row strobe / column debounce for a 4x4 keypad; emits one key code per press.
// Decisions on clk_lento ticks, 2 clk column sync; key_valid held until key_ready.
module keypad_scan_driver
   import keypad_pkg::*;
#(
   parameter int SETTLE_TICKS   = 2,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clk_lento,
   input  logic [COLS-1:0]  i_col_in,
   output logic [ROWS-1:0]  o_row_out,
   output logic [KEY_W-1:0] o_key_code,
   output logic             o_key_valid,
   input  logic             i_key_ready,
   output logic             o_key_down
);
   localparam int CNT_MAX = (SETTLE_TICKS > DEBOUNCE_TICKS) ? SETTLE_TICKS : DEBOUNCE_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_TICKS);
   localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE_TICKS);

   logic [COLS-1:0]  w_col_s;
   logic [COLS-1:0]  w_pat;
   logic [CNT_W-1:0] w_cnt_inc;

   state_t           r_state, w_state;
   logic [1:0]       r_row,   w_row;
   logic [CNT_W-1:0] r_cnt,   w_cnt;
   logic [KEY_W-1:0] r_code,  w_code;
   logic             r_down,  w_down;

   col_sync #(.W(COLS)) u_col_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_col_in),
      .o_q   (w_col_s)
   );

   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
   assign w_pat     = ~(COLS'(1) << r_code[1:0]);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= SCAN;
         r_row   <= '0;
         r_cnt   <= '0;
         r_code  <= '0;
         r_down  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_row   <= w_row;
         r_cnt   <= w_cnt;
         r_code  <= w_code;
         r_down  <= w_down;
      end
   end

   always_comb begin
      w_state = r_state;
      w_row   = r_row;
      w_cnt   = r_cnt;
      w_code  = r_code;
      w_down  = r_down;
      case (r_state)
         SCAN: if (i_clk_lento) begin
            if (r_cnt < SETTLE_C) begin
               w_cnt = w_cnt_inc;
            end else if (one_low(w_col_s)) begin
               w_code = {r_row, low_pos(w_col_s)};
               w_cnt  = CNT_W'(1);
               if (DEBOUNCE_TICKS <= 1) begin
                  w_state = REPORT;
                  w_down  = 1'b1;
               end else begin
                  w_state = CONFIRM;
               end
            end else begin
               w_row = r_row + 1'b1;
               w_cnt = '0;
            end
         end
         CONFIRM: if (i_clk_lento) begin
            if (w_col_s == w_pat) begin
               w_cnt = w_cnt_inc;
               if (w_cnt_inc >= DEB_C) begin
                  w_state = REPORT;
                  w_down  = 1'b1;
               end
            end else begin
               w_row   = r_row + 1'b1;
               w_cnt   = '0;
               w_state = SCAN;
            end
         end
         // Ticks are deliberately ignored here; only the handshake moves on.
         REPORT: if (i_key_ready) begin
            w_state = RELEASE;
            w_cnt   = '0;
         end
         RELEASE: if (i_clk_lento) begin
            if (&w_col_s) begin
               w_cnt = w_cnt_inc;
               if (w_cnt_inc >= DEB_C) begin
                  w_down  = 1'b0;
                  w_row   = r_row + 1'b1;
                  w_cnt   = '0;
                  w_state = SCAN;
               end
            end else begin
               w_cnt = '0;
            end
         end
         default: w_state = SCAN;
      endcase
   end

   assign o_row_out   = ROW_IDLE & ~(ROWS'(1) << r_row);
   assign o_key_code  = r_code;
   assign o_key_valid = (r_state == REPORT);
   assign o_key_down  = r_down;
endmodule

// File: tb/tb_keypad_scan_driver.sv
// Directed bench for keypad_scan_driver with a tick-level reference model.
module tb_keypad_scan_driver;
   localparam int SETTLE = 2;
   localparam int DEB    = 4;

   logic       clk;
   logic       rst_drv;
   logic       tick_drv;
   logic       ready_drv;
   logic [3:0] col_drv;
   logic [3:0] row_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   int         n_checks = 0;
   int         n_errors = 0;

   // stimulus controls
   bit         press_en = 0;
   bit         bounce   = 0;
   int         press_row = 0;
   logic [3:0] press_pat = 4'hF;
   int         tcnt = 0;

   // reference model state
   bit         m_live = 0;
   int         m_mode = 0;      // 0 hunting, 1 verifying, 2 offering, 3 awaiting release
   int         m_row = 0, m_wait = 0, m_run = 0, m_code = 0;
   bit         m_valid = 0, m_down = 0;
   logic [3:0] c0 = 4'hF, c1 = 4'hF;
   int         tick_seen = 0;
   int         vcount = 0;

   keypad_scan_driver #(.SETTLE_TICKS(SETTLE), .DEBOUNCE_TICKS(DEB)) dut (
      .i_clk       (clk),
      .i_rst       (rst_drv),
      .i_clk_lento (tick_drv),
      .i_col_in    (col_drv),
      .o_row_out   (row_out),
      .o_key_code  (key_code),
      .o_key_valid (key_valid),
      .i_key_ready (ready_drv),
      .o_key_down  (key_down)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // Input driver: tick every 4 clk, keypad switch model reacting to the row strobes.
   initial begin
      logic [3:0] sel;
      tick_drv = 0;
      col_drv  = 4'hF;
      forever begin
         @(negedge clk);
         if (!rst_drv) tcnt = 0; else tcnt++;
         tick_drv = rst_drv && (tcnt % 4 == 0) && (tcnt != 0);
         sel = 4'hF ^ (4'b0001 << press_row);
         if (bounce)                          col_drv = 4'hF;
         else if (press_en && row_out == sel) col_drv = press_pat;
         else                                 col_drv = 4'hF;
      end
   end

   // Reference model: evaluated on each rising edge from the bench's own input values.
   initial begin
      logic [3:0] cs;
      int lows, pos;
      forever begin
         @(posedge clk);
         if (!rst_drv) begin
            m_mode = 0; m_row = 0; m_wait = 0; m_run = 0; m_code = 0;
            m_valid = 0; m_down = 0; c0 = 4'hF; c1 = 4'hF; m_live = 1;
         end else begin
            cs = c1;
            lows = 0; pos = 0;
            for (int i = 0; i < 4; i++) if (!cs[i]) begin lows++; pos = i; end
            if (tick_drv) tick_seen++;
            if (m_mode == 0 && tick_drv) begin
               if (m_wait < SETTLE) m_wait++;
               else if (lows == 1) begin
                  m_code = m_row * 4 + pos;
                  m_run  = 1;
                  if (m_run >= DEB) begin m_mode = 2; m_valid = 1; m_down = 1; end
                  else m_mode = 1;
               end else begin
                  m_row = (m_row + 1) % 4; m_wait = 0;
               end
            end else if (m_mode == 1 && tick_drv) begin
               if (lows == 1 && pos == m_code % 4) begin
                  m_run++;
                  if (m_run == DEB) begin m_mode = 2; m_valid = 1; m_down = 1; end
               end else begin
                  m_row = (m_row + 1) % 4; m_wait = 0; m_mode = 0;
               end
            end else if (m_mode == 2) begin
               if (ready_drv) begin m_valid = 0; m_mode = 3; m_run = 0; end
            end else if (m_mode == 3 && tick_drv) begin
               m_run = (cs == 4'hF) ? m_run + 1 : 0;
               if (m_run == DEB) begin
                  m_down = 0; m_row = (m_row + 1) % 4; m_wait = 0; m_mode = 0;
               end
            end
            c1 = c0;
            c0 = col_drv;
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      logic [3:0] exp_row;
      forever begin
         @(negedge clk);
         if (m_live) begin
            exp_row = 4'hF ^ (4'b0001 << m_row);
            chk("row_out", row_out, exp_row);
            chk("key_code", key_code, m_code);
            chk("key_valid", key_valid, m_valid);
            chk("key_down", key_down, m_down);
            if (key_valid === 1'b1) vcount++;
         end
      end
   end

   task automatic wait_ticks(input int n);
      int target = tick_seen + n;
      int g = 0;
      while (tick_seen < target && g < 1000) begin @(negedge clk); g++; end
      if (tick_seen < target) timeout_fail("wait_ticks");
   endtask

   task automatic wait_valid(input int n);
      int g = 0;
      while (key_valid !== 1'b1 && g < n) begin @(negedge clk); g++; end
      if (key_valid !== 1'b1) timeout_fail("wait_valid");
   endtask

   task automatic wait_up(input int n);
      int g = 0;
      while (key_down !== 1'b0 && g < n) begin @(negedge clk); g++; end
      if (key_down !== 1'b0) timeout_fail("wait_key_up");
   endtask

   task automatic wait_confirm(input int n);
      int g = 0;
      while (m_mode != 1 && g < n) begin @(negedge clk); g++; end
      if (m_mode != 1) timeout_fail("wait_confirm");
   endtask

   initial begin
      int v0;
      rst_drv   = 0;
      ready_drv = 1;
      repeat (3) @(negedge clk);
      chk("reset_row", row_out, 4'b1110);
      chk("reset_valid", key_valid, 0);
      chk("reset_down", key_down, 0);
      chk("reset_code", key_code, 0);
      rst_drv = 1;

      // idle scan: three ticks per empty row
      wait_ticks(3); chk("scan_t3", row_out, 4'b1101);
      wait_ticks(3); chk("scan_t6", row_out, 4'b1011);
      wait_ticks(3); chk("scan_t9", row_out, 4'b0111);
      wait_ticks(3); chk("scan_t12", row_out, 4'b1110);

      // press row 2 / col 1 with ready tied high
      v0 = vcount;
      press_row = 2; press_pat = 4'b1101; press_en = 1;
      wait_valid(600);
      chk("press_code", key_code, 4'h9);
      @(negedge clk);
      chk("press_valid_1cyc", key_valid, 0);
      chk("press_down", key_down, 1);
      press_en = 0;
      wait_up(600);
      chk("release_row3", row_out, 4'b0111);
      chk("press_vcount", vcount - v0, 1);

      // bounce on the second confirm tick
      v0 = vcount;
      press_row = 0; press_pat = 4'b0111; press_en = 1;
      wait_confirm(600);
      wait_ticks(1);
      bounce = 1;
      wait_ticks(1);
      chk("bounce_row1", row_out, 4'b1101);
      chk("bounce_no_valid", vcount - v0, 0);
      bounce = 0; press_en = 0;

      // backpressure on row 3 / col 0
      ready_drv = 0;
      press_row = 3; press_pat = 4'b1110; press_en = 1;
      wait_valid(800);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_valid", key_valid, 1);
         chk("bp_code", key_code, 4'hC);
         chk("bp_row", row_out, 4'b0111);
      end
      ready_drv = 1;
      @(negedge clk);
      chk("bp_accept", key_valid, 0);
      press_en = 0;
      wait_up(600);

      // two columns low on row 1 is not a key
      v0 = vcount;
      press_row = 1; press_pat = 4'b1001; press_en = 1;
      wait_ticks(15);
      chk("multi_no_valid", vcount - v0, 0);
      chk("multi_no_down", key_down, 0);
      press_en = 0;

      // reset while a key is being offered
      ready_drv = 0;
      press_row = 1; press_pat = 4'b1011; press_en = 1;
      wait_valid(800);
      chk("rst_pre_code", key_code, 4'h6);
      rst_drv = 0;
      @(negedge clk);
      chk("rst_mid_valid", key_valid, 0);
      chk("rst_mid_row", row_out, 4'b1110);
      press_en = 0;
      rst_drv  = 1;
      v0 = vcount;
      wait_ticks(16);
      chk("rst_no_key", vcount - v0, 0);
      ready_drv = 1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end
endmodule
